v_timing_gen: RTL and testbench

V_TIMING_GEN -- requirements
Module: v_timing_gen

---
 rtl/v_timing_gen_if.sv | 25 ++
 rtl/v_timing_gen.sv | 77 +++++++
 tb/tb_v_timing_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/v_timing_gen_if.sv
// Vertical timing bus: line strobe in from the horizontal stage, frame timing out.
// master = timing generator side, slave = horizontal stage / display consumer side.
interface v_timing_gen_if;
   logic       EndLine;
   logic       vsync;
   logic       v_nblank;
   logic       EndFrame;
   logic [9:0] row;

   modport master (
      input  EndLine,
      output vsync,
      output v_nblank,
      output EndFrame,
      output row
   );

   modport slave (
      output EndLine,
      input  vsync,
      input  v_nblank,
      input  EndFrame,
      input  row
   );
endinterface

// File: rtl/v_timing_gen.sv
// Vertical video timing generator: counts EndLine strobes through sync, back porch,
// active and front porch regions, and decodes vsync/blank/row/EndFrame from that state.
module v_timing_gen #(
   parameter int unsigned VSYNC_LINES   = 2,
   parameter int unsigned VBP_LINES     = 33,
   parameter int unsigned VACTIVE_LINES = 480,
   parameter int unsigned VFP_LINES     = 10
) (
   input  logic           sys_clk,
   input  logic           reset,
   v_timing_gen_if.master bus
);

   typedef enum logic [1:0] {
      S_VSYNC   = 2'd0,
      S_VBP     = 2'd1,
      S_VACTIVE = 2'd2,
      S_VFP     = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_cnt;
   logic [9:0] w_cnt_nxt;
   logic [9:0] w_len;
   logic       w_last;

   // Length of the region currently being counted, in lines.
   always_comb begin
      w_len = 10'(VSYNC_LINES);
      case (r_state)
         S_VSYNC:   w_len = 10'(VSYNC_LINES);
         S_VBP:     w_len = 10'(VBP_LINES);
         S_VACTIVE: w_len = 10'(VACTIVE_LINES);
         S_VFP:     w_len = 10'(VFP_LINES);
      endcase
   end

   assign w_last = (r_cnt == (w_len - 10'd1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_VSYNC;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: hold values are assigned first so every path drives both signals and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (bus.EndLine) begin
         if (w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
               S_VSYNC:   w_state_nxt = S_VBP;
               S_VBP:     w_state_nxt = S_VACTIVE;
               S_VACTIVE: w_state_nxt = S_VFP;
               S_VFP:     w_state_nxt = S_VSYNC;
            endcase
         end else begin
            w_cnt_nxt = r_cnt + 10'd1;
         end
      end
   end

   assign bus.vsync    = (r_state != S_VSYNC);
   assign bus.v_nblank = (r_state == S_VACTIVE);
   assign bus.row      = (r_state == S_VACTIVE) ? r_cnt : 10'd0;
   // Zero-latency strobe on the final front-porch line; reset forces VSYNC so it cannot fire then.
   assign bus.EndFrame = (r_state == S_VFP) && w_last && bus.EndLine;

endmodule

// File: tb/tb_v_timing_gen.sv
// Directed bench for v_timing_gen: three instances (2/3/4/2, defaults, all-ones)
// driven from hand-computed vector tables and short corner-case sequences.
module tb_v_timing_gen;

   logic sys_clk = 1'b0;
   logic reset;

   always #5 sys_clk = ~sys_clk;

   v_timing_gen_if if_a ();
   v_timing_gen_if if_b ();
   v_timing_gen_if if_c ();

   v_timing_gen #(
      .VSYNC_LINES(2), .VBP_LINES(3), .VACTIVE_LINES(4), .VFP_LINES(2)
   ) u_a (
      .sys_clk(sys_clk),
      .reset  (reset),
      .bus    (if_a)
   );

   v_timing_gen u_b (
      .sys_clk(sys_clk),
      .reset  (reset),
      .bus    (if_b)
   );

   v_timing_gen #(
      .VSYNC_LINES(1), .VBP_LINES(1), .VACTIVE_LINES(1), .VFP_LINES(1)
   ) u_c (
      .sys_clk(sys_clk),
      .reset  (reset),
      .bus    (if_c)
   );

   typedef struct {
      logic       el;
      logic       vs;
      logic       nb;
      logic       ef;
      logic [9:0] row;
   } vec_t;

   vec_t tbl_a[12];
   vec_t tbl_c[4];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic el, input logic vs, input logic nb,
                               input logic ef, input logic [9:0] row);
      vec_t v;
      v.el  = el;
      v.vs  = vs;
      v.nb  = nb;
      v.ef  = ef;
      v.row = row;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic vs, input logic nb, input logic ef,
                          input logic [9:0] row, input vec_t e);
      check({tag, "_vsync"},    {31'b0, vs},  {31'b0, e.vs});
      check({tag, "_v_nblank"}, {31'b0, nb},  {31'b0, e.nb});
      check({tag, "_EndFrame"}, {31'b0, ef},  {31'b0, e.ef});
      check({tag, "_row"},      {22'b0, row}, {22'b0, e.row});
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   // Asserts reset at the current time (away from the edge) with EndLine high on every DUT.
   task automatic do_reset();
      vec_t z;
      z = mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      reset = 1'b0;
      if_a.EndLine = 1'b1;
      if_b.EndLine = 1'b1;
      if_c.EndLine = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_out("rst_a", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row, z);
         chk_out("rst_b", if_b.vsync, if_b.v_nblank, if_b.EndFrame, if_b.row, z);
         chk_out("rst_c", if_c.vsync, if_c.v_nblank, if_c.EndFrame, if_c.row, z);
         cyc();
      end
      if_a.EndLine = 1'b0;
      if_b.EndLine = 1'b0;
      if_c.EndLine = 1'b0;
      reset = 1'b1;
      cyc();
   endtask

   task automatic pulse_a(input int n);
      for (int k = 0; k < n; k++) begin
         if_a.EndLine = 1'b1;
         cyc();
         if_a.EndLine = 1'b0;
         cyc();
      end
   endtask

   // One frame plus the first line of the next, with `gap` idle cycles before each strobe.
   task automatic run_a_table(input int gap);
      for (int i = 0; i < 12; i++) begin
         for (int g = 0; g < gap; g++) begin
            if_a.EndLine = 1'b0;
            #1;
            chk_out("a_idle", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row,
                    mk(1'b0, tbl_a[i].vs, tbl_a[i].nb, 1'b0, tbl_a[i].row));
            cyc();
         end
         if_a.EndLine = tbl_a[i].el;
         #1;
         chk_out("a_line", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row, tbl_a[i]);
         cyc();
      end
      if_a.EndLine = 1'b0;
   endtask

   initial begin
      int ef_cnt;
      int ef_pos[2];
      int nb_lines;
      int vs_lines;
      int max_row;

      // 2/3/4/2: lines 0-1 sync, 2-4 back porch, 5-8 active, 9-10 front porch, 11 wraps.
      tbl_a[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      tbl_a[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      tbl_a[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      tbl_a[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      tbl_a[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      tbl_a[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
      tbl_a[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd1);
      tbl_a[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd2);
      tbl_a[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd3);
      tbl_a[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      tbl_a[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'd0);
      tbl_a[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);

      // All-ones: one state per strobe, EndFrame on every fourth.
      tbl_c[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      tbl_c[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      tbl_c[2] = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd0);
      tbl_c[3] = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'd0);

      reset = 1'b0;
      if_a.EndLine = 1'b0;
      if_b.EndLine = 1'b0;
      if_c.EndLine = 1'b0;
      cyc();

      do_reset();
      run_a_table(4);

      do_reset();
      run_a_table(100);

      // EndLine held high three cycles starting at back porch line 0.
      do_reset();
      pulse_a(2);
      if_a.EndLine = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_out("a_hold", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row,
                 mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
         cyc();
      end
      if_a.EndLine = 1'b0;
      #1;
      chk_out("a_hold_act0", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row,
              mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0));
      cyc();
      pulse_a(1);
      #1;
      chk_out("a_hold_act1", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row,
              mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd1));
      cyc();

      // Reset in the middle of the active region at row 2, then a clean frame.
      do_reset();
      pulse_a(7);
      #1;
      chk_out("a_pre_rst", if_a.vsync, if_a.v_nblank, if_a.EndFrame, if_a.row,
              mk(1'b0, 1'b1, 1'b1, 1'b0, 10'd2));
      do_reset();
      run_a_table(1);

      // All-ones instance with EndLine held high continuously.
      do_reset();
      if_c.EndLine = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk_out("c_line", if_c.vsync, if_c.v_nblank, if_c.EndFrame, if_c.row, tbl_c[k % 4]);
         cyc();
      end
      if_c.EndLine = 1'b0;
      #1;
      chk_out("c_end", if_c.vsync, if_c.v_nblank, if_c.EndFrame, if_c.row,
              mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0));
      cyc();

      // Default parameters, two full frames.
      do_reset();
      ef_cnt    = 0;
      ef_pos[0] = 0;
      ef_pos[1] = 0;
      nb_lines  = 0;
      vs_lines  = 0;
      max_row   = 0;
      for (int n = 1; n <= 1050; n++) begin
         if_b.EndLine = 1'b1;
         #1;
         if (if_b.v_nblank === 1'b1) nb_lines++;
         if (if_b.vsync === 1'b0) vs_lines++;
         if (int'(if_b.row) > max_row) max_row = int'(if_b.row);
         if (if_b.EndFrame === 1'b1) begin
            if (ef_cnt < 2) ef_pos[ef_cnt] = n;
            ef_cnt++;
         end
         cyc();
         if_b.EndLine = 1'b0;
         #1;
         if (if_b.EndFrame !== 1'b0) ef_cnt++;
         cyc();
      end
      check("b_endframe_count", ef_cnt,    2);
      check("b_endframe_pos0",  ef_pos[0], 525);
      check("b_endframe_pos1",  ef_pos[1], 1050);
      check("b_active_lines",   nb_lines,  960);
      check("b_vsync_lines",    vs_lines,  4);
      check("b_max_row",        max_row,   479);
      #1;
      chk_out("b_wrap", if_b.vsync, if_b.v_nblank, if_b.EndFrame, if_b.row,
              mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
